// File: rtl/scan_mux_pkg.sv
// Shared constants and channel-advance helper for the scan_mux display multiplexer.
package scan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // The helper works on the widest supported configuration; callers zero-extend.
    localparam int unsigned MASK_W = 16;
    localparam int unsigned IDX_W  = 4;

    // Returns {wrap, idx}: lowest enabled index above cur, else lowest enabled with wrap set.
    // An empty mask leaves cur unchanged and never wraps.
    function automatic logic [IDX_W:0] next_enabled(input logic [MASK_W-1:0] mask,
                                                     input logic [IDX_W-1:0]  cur);
        logic             found;
        logic             wrap;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        wrap  = 1'b0;
        idx   = cur;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = MASK_W - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    idx  = IDX_W'(i);
                    wrap = 1'b1;
                end
            end
        end
        return {wrap, idx};
    endfunction

endpackage

// File: rtl/scan_mux_dwell_timer.sv
// Dwell counter for SCAN mode: counts 0..DWELL-1 while run is high, tick on the last count.
module scan_mux_dwell_timer #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned            CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]       LAST  = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scan_mux.sv
// N-channel registered multiplexer: MANUAL select or SCAN round-robin over enabled channels.
module scan_mux #(
    parameter int unsigned N_CH  = 7,
    parameter int unsigned W     = 1,
    parameter int unsigned SEL_W = $clog2(N_CH),
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH*W-1:0] in_bus,
    input  logic [SEL_W-1:0]  sel,
    input  logic              mode,
    input  logic [N_CH-1:0]   ch_en,
    output logic [W-1:0]      out,
    output logic [SEL_W-1:0]  cur_ch,
    output logic              valid,
    output logic              wrap
);

    import scan_mux_pkg::*;

    logic [W-1:0]     r_out;
    logic [SEL_W-1:0] r_cur_ch;
    logic             r_valid;
    logic             r_wrap;

    logic             w_run;
    logic             w_tick;
    logic [IDX_W:0]   w_nxt;
    logic [SEL_W-1:0] w_ch_nxt;
    logic [W-1:0]     w_out_nxt;
    logic             w_valid_nxt;
    logic             w_wrap_nxt;
    logic [W-1:0]     w_ch_data [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign w_ch_data[k] = in_bus[k*W +: W];
    end

    assign w_run = (mode == MODE_SCAN);
    assign w_nxt = next_enabled(MASK_W'(ch_en), IDX_W'(r_cur_ch));

    scan_mux_dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Output data is chosen from the channel that cur_ch will show, so out and cur_ch agree.
    always_comb begin
        w_ch_nxt    = sel;
        w_wrap_nxt  = 1'b0;
        w_out_nxt   = '0;
        w_valid_nxt = 1'b0;
        if (w_run) begin
            w_ch_nxt   = w_tick ? SEL_W'(w_nxt[IDX_W-1:0]) : r_cur_ch;
            w_wrap_nxt = w_tick && w_nxt[IDX_W];
        end
        if (32'(w_ch_nxt) < N_CH) begin
            if (ch_en[w_ch_nxt]) begin
                w_out_nxt   = w_ch_data[w_ch_nxt];
                w_valid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out    <= '0;
            r_cur_ch <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_out    <= w_out_nxt;
            r_cur_ch <= w_ch_nxt;
            r_valid  <= w_valid_nxt;
            r_wrap   <= w_wrap_nxt;
        end
    end

    assign out    = r_out;
    assign cur_ch = r_cur_ch;
    assign valid  = r_valid;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux with a cycle-level behavioural model and literal spot checks.
module tb_scan_mux;

    localparam int N_CH  = 7;
    localparam int W     = 4;
    localparam int SEL_W = 3;
    localparam int DWELL = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N_CH*W-1:0] in_bus;
    logic [SEL_W-1:0]  sel;
    logic              mode;
    logic [N_CH-1:0]   ch_en;
    logic [W-1:0]      out;
    logic [SEL_W-1:0]  cur_ch;
    logic              valid;
    logic              wrap;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state
    int       m_ch  = 0;
    int       m_cnt = 0;
    logic [W-1:0] m_out = '0;
    bit       m_valid = 1'b0;
    bit       m_wrap  = 1'b0;

    scan_mux #(
        .N_CH  (N_CH),
        .W     (W),
        .DWELL (DWELL)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_bus (in_bus),
        .sel    (sel),
        .mode   (mode),
        .ch_en  (ch_en),
        .out    (out),
        .cur_ch (cur_ch),
        .valid  (valid),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behaviour from the rules: manual follows sel, scan dwells DWELL cycles then moves on.
    task automatic model_step();
        int en_list[$];
        int nxt;
        if (reset) begin
            m_ch = 0; m_cnt = 0; m_wrap = 1'b0;
        end else if (mode == 1'b0) begin
            m_ch = int'(sel); m_cnt = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (m_cnt == DWELL - 1) begin
                m_cnt = 0;
                for (int k = 0; k < N_CH; k++) if (ch_en[k]) en_list.push_back(k);
                if (en_list.size() > 0) begin
                    nxt = -1;
                    foreach (en_list[j]) if (en_list[j] > m_ch && nxt < 0) nxt = en_list[j];
                    if (nxt < 0) begin
                        nxt = en_list[0];
                        m_wrap = 1'b1;
                    end
                    m_ch = nxt;
                end
            end else begin
                m_cnt++;
            end
        end
        m_valid = !reset && (m_ch < N_CH) && ch_en[m_ch];
        m_out   = m_valid ? in_bus[m_ch*W +: W] : '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_out", 32'(out), 32'(m_out));
            check("cmp_cur_ch", 32'(cur_ch), 32'(m_ch));
            check("cmp_valid", 32'(valid), 32'(m_valid));
            check("cmp_wrap", 32'(wrap), 32'(m_wrap));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq[12] = '{0, 0, 0, 2, 2, 2, 2, 4, 4, 4, 4, 0};
        reset  = 1'b1;
        mode   = 1'b0;
        sel    = 3'd3;
        ch_en  = 7'h7F;
        in_bus = 28'h9ECA751;  // ch6..ch0 = 9,E,C,A,7,5,1

        // Reset behaviour
        cyc();
        cmp_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("rst_out", 32'(out), 32'h0);
            check("rst_valid", 32'(valid), 32'h0);
            check("rst_cur_ch", 32'(cur_ch), 32'h0);
            check("rst_wrap", 32'(wrap), 32'h0);
            if (i == 0) cyc();
        end
        reset = 1'b0;
        cyc();
        check("rel_out", 32'(out), 32'hA);
        check("rel_cur_ch", 32'(cur_ch), 32'd3);
        check("rel_valid", 32'(valid), 32'h1);

        // Out-of-range select, then masked channel
        sel = 3'd7;
        cyc();
        check("oor_out", 32'(out), 32'h0);
        check("oor_valid", 32'(valid), 32'h0);
        check("oor_cur_ch", 32'(cur_ch), 32'd7);
        sel   = 3'd2;
        ch_en = 7'h7B;
        cyc();
        check("mask_out", 32'(out), 32'h0);
        check("mask_valid", 32'(valid), 32'h0);
        check("mask_cur_ch", 32'(cur_ch), 32'd2);

        // Scan over channels 0/2/4
        sel   = 3'd0;
        ch_en = 7'b0010101;
        cyc();
        check("pre_scan_out", 32'(out), 32'h1);
        mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("scan_seq_cur_ch", 32'(cur_ch), 32'(exp_seq[i]));
            check("scan_seq_wrap", 32'(wrap), (i == 11) ? 32'h1 : 32'h0);
            if (i == 4) in_bus[2*W +: W] = 4'h3;
            if (i == 5) check("scan_live_out", 32'(out), 32'h3);
        end

        // Empty mask: hold, invalid, no wrap
        ch_en = 7'h00;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("empty_cur_ch", 32'(cur_ch), 32'h0);
            check("empty_valid", 32'(valid), 32'h0);
            check("empty_wrap", 32'(wrap), 32'h0);
        end
        ch_en = 7'h40;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("solo_hold_cur_ch", 32'(cur_ch), 32'h0);
        end
        cyc();
        check("solo_cur_ch", 32'(cur_ch), 32'd6);
        check("solo_out", 32'(out), 32'h9);
        check("solo_wrap", 32'(wrap), 32'h0);

        // Mid-dwell detour through MANUAL
        ch_en = 7'h7F;
        cyc();
        cyc();
        mode = 1'b0;
        sel  = 3'd5;
        cyc();
        check("detour_cur_ch", 32'(cur_ch), 32'd5);
        check("detour_out", 32'(out), 32'hE);
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("detour_hold", 32'(cur_ch), 32'd5);
            if (i == 0) in_bus[5*W +: W] = 4'h2;
            if (i == 1) check("detour_live_out", 32'(out), 32'h2);
        end
        cyc();
        check("detour_adv", 32'(cur_ch), 32'd6);

        // Reset pulse mid-sweep at channel 4
        ch_en = 7'b0010101;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (i == 3) check("sweep_wrap", 32'(wrap), 32'h1);
        end
        check("sweep_at4", 32'(cur_ch), 32'd4);
        cyc();
        reset = 1'b1;
        cyc();
        check("midrst_cur_ch", 32'(cur_ch), 32'h0);
        check("midrst_out", 32'(out), 32'h0);
        check("midrst_valid", 32'(valid), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("resume_hold", 32'(cur_ch), 32'h0);
            check("resume_out", 32'(out), 32'h1);
        end
        cyc();
        check("resume_adv", 32'(cur_ch), 32'd2);
        check("resume_adv_out", 32'(out), 32'h3);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
